// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared register-file widths, writeback request type and x0 constant
package regfile_pkg;

   localparam int XLEN     = 32;
   localparam int AW       = 5;
   localparam int NUM_REGS = 2 ** AW;

   typedef struct packed {
      logic [AW-1:0]   addr;
      logic [XLEN-1:0] data;
   } wb_req_t;

   localparam logic [AW-1:0] ZERO_REG = '0;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// rtl/regfile_wb_arbiter_if.sv - writeback request, write-port and read-forwarding signal bundle
interface regfile_wb_arbiter_if #(
   parameter int N_REQ = 3,
   parameter int XLEN  = regfile_pkg::XLEN,
   parameter int AW    = regfile_pkg::AW
);

   logic                  hold;
   logic [N_REQ-1:0]      req_valid;
   logic [N_REQ*AW-1:0]   req_addr;
   logic [N_REQ*XLEN-1:0] req_data;
   logic [N_REQ-1:0]      req_ready;
   logic                  rf_we;
   logic [AW-1:0]         rf_wa;
   logic [XLEN-1:0]       rf_wd;
   logic [AW-1:0]         rd_a1;
   logic [AW-1:0]         rd_a2;
   logic [XLEN-1:0]       rf_rd1;
   logic [XLEN-1:0]       rf_rd2;
   logic [XLEN-1:0]       fwd_rd1;
   logic [XLEN-1:0]       fwd_rd2;

   modport master (
      output hold, req_valid, req_addr, req_data, rd_a1, rd_a2, rf_rd1, rf_rd2,
      input  req_ready, rf_we, rf_wa, rf_wd, fwd_rd1, fwd_rd2
   );

   modport slave (
      input  hold, req_valid, req_addr, req_data, rd_a1, rd_a2, rf_rd1, rf_rd2,
      output req_ready, rf_we, rf_wa, rf_wd, fwd_rd1, fwd_rd2
   );

endinterface

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// rtl/regfile_wb_arbiter_rr_arbiter.sv - combinational round-robin arbiter, search starts after ptr
module rr_arbiter #(
   parameter int N  = 3,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  grant,
   output logic [IW-1:0] grant_idx,
   output logic          grant_any
);

   int            idx;
   logic [IW-1:0] sel;

   always_comb begin
      grant     = '0;
      grant_idx = ptr;
      grant_any = 1'b0;
      idx       = 0;
      sel       = '0;
      // Offsets 1..N visit every index once, ending on ptr itself (lowest priority).
      for (int off = 1; off <= N; off++) begin
         idx = int'(ptr) + off;
         if (idx >= N) idx = idx - N;
         sel = IW'(idx);
         if (!grant_any && req[sel]) begin
            grant_any  = 1'b1;
            grant[sel] = 1'b1;
            grant_idx  = sel;
         end
      end
   end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - round-robin share of the register-file write port with read forwarding
module regfile_wb_arbiter #(
   parameter int N_REQ = 3,
   parameter int XLEN  = regfile_pkg::XLEN,
   parameter int AW    = regfile_pkg::AW
) (
   input logic                clk,
   input logic                rst,
   regfile_wb_arbiter_if.slave bus
);

   import regfile_pkg::*;

   localparam int IW = $clog2(N_REQ);

   logic [N_REQ-1:0] arb_req;
   logic [N_REQ-1:0] grant;
   logic [IW-1:0]    grant_idx;
   logic             grant_any;
   logic [IW-1:0]    rr_ptr;

   logic             we_q;
   logic [AW-1:0]    wa_q;
   logic [XLEN-1:0]  wd_q;
   logic [AW-1:0]    win_addr;
   logic [XLEN-1:0]  win_data;

   // Masking the requests (not the grant) keeps rr_ptr untouched during hold/reset.
   assign arb_req = bus.req_valid & {N_REQ{~(bus.hold | rst)}};

   rr_arbiter #(.N(N_REQ), .IW(IW)) u_rr_arbiter (
      .req       (arb_req),
      .ptr       (rr_ptr),
      .grant     (grant),
      .grant_idx (grant_idx),
      .grant_any (grant_any)
   );

   assign bus.req_ready = grant;
   assign win_addr      = bus.req_addr[grant_idx*AW +: AW];
   assign win_data      = bus.req_data[grant_idx*XLEN +: XLEN];

   always_ff @(posedge clk) begin
      if (rst) begin
         we_q   <= 1'b0;
         wa_q   <= '0;
         wd_q   <= '0;
         rr_ptr <= IW'(N_REQ - 1);
      end else if (grant_any) begin
         rr_ptr <= grant_idx;
         we_q   <= (win_addr != AW'(ZERO_REG));
         wa_q   <= win_addr;
         wd_q   <= win_data;
      end else begin
         we_q   <= 1'b0;
      end
   end

   // Gating with rst drops an accepted write whose commit edge coincides with reset.
   assign bus.rf_we = we_q & ~rst;
   assign bus.rf_wa = wa_q;
   assign bus.rf_wd = wd_q;

   assign bus.fwd_rd1 = (bus.rf_we && bus.rf_wa == bus.rd_a1 && bus.rd_a1 != AW'(ZERO_REG))
                        ? bus.rf_wd : bus.rf_rd1;
   assign bus.fwd_rd2 = (bus.rf_we && bus.rf_wa == bus.rd_a2 && bus.rd_a2 != AW'(ZERO_REG))
                        ? bus.rf_wd : bus.rf_rd2;

endmodule
